// File: rtl/tmr_pkg.sv
// Shared scrubber state encoding and the bitwise majority primitive for the TMR register bank.
package tmr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CHECK,
        FIX,
        NEXT
    } scrub_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (c & a);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Majority voter over three copies of a word, with a flag raised when any copy disagrees.
module tmr_vote
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] c0_i,
    input  logic [WIDTH-1:0] c1_i,
    input  logic [WIDTH-1:0] c2_i,
    output logic [WIDTH-1:0] vote_o,
    output logic             mismatch_o
);

    always_comb begin
        vote_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            vote_o[i] = maj3(c0_i[i], c1_i[i], c2_i[i]);
        end
        mismatch_o = (c0_i != c1_i) || (c1_i != c2_i);
    end

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// Triplicated register bank with voted reads and a background scrubber that repairs disagreeing copies.
// Define TMR_FAULT_INJECT_EN to add the single-bit fault injection ports.
module tmr_scrub_ctrl
    import tmr_pkg::*;
#(
    parameter int unsigned      DEPTH     = 8,
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 8,
    localparam int unsigned     AW        = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [AW-1:0]            rd_addr,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     scrub_en,
    input  logic [CNT_W-1:0]         scrub_period,
    output logic                     busy,
    output logic                     err_pulse,
    output logic [AW-1:0]            err_addr,
`ifdef TMR_FAULT_INJECT_EN
    input  logic                     inj_en,
    input  logic [AW-1:0]            inj_addr,
    input  logic [1:0]               inj_copy,
    input  logic [$clog2(WIDTH)-1:0] inj_bit,
`endif
    output logic [CNT_W-1:0]         err_cnt
);

    scrub_state_e                 state_q, state_d;
    logic [DEPTH-1:0][WIDTH-1:0]  cp0_q, cp1_q, cp2_q;
    logic [DEPTH-1:0][WIDTH-1:0]  cp0_d, cp1_d, cp2_d;
    logic [AW-1:0]                addr_q, addr_d;
    logic [CNT_W-1:0]             ctr_q, ctr_d;
    logic [CNT_W-1:0]             err_cnt_q, err_cnt_d;
    logic [AW-1:0]                err_addr_q, err_addr_d;
    logic [WIDTH-1:0]             sc_vote;
    logic                         sc_mismatch;
    logic                         rd_mismatch_unused;
    logic                         wr_hit;

    tmr_vote #(.WIDTH(WIDTH)) u_rd_vote (
        .c0_i       (cp0_q[rd_addr]),
        .c1_i       (cp1_q[rd_addr]),
        .c2_i       (cp2_q[rd_addr]),
        .vote_o     (rd_data),
        .mismatch_o (rd_mismatch_unused)
    );

    tmr_vote #(.WIDTH(WIDTH)) u_sc_vote (
        .c0_i       (cp0_q[addr_q]),
        .c1_i       (cp1_q[addr_q]),
        .c2_i       (cp2_q[addr_q]),
        .vote_o     (sc_vote),
        .mismatch_o (sc_mismatch)
    );

    assign wr_hit = wr_en && (wr_addr == addr_q);

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A host write to the word under check makes the repair moot, so it skips FIX.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scrub_en) state_d = WAIT;
            WAIT:    if (ctr_q == '0) state_d = CHECK;
            CHECK:   state_d = (sc_mismatch && !wr_hit) ? FIX : NEXT;
            FIX:     state_d = NEXT;
            NEXT:    state_d = scrub_en ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        err_pulse = (state_q == FIX);
    end

    always_comb begin
        ctr_d      = ctr_q;
        addr_d     = addr_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        cp0_d      = cp0_q;
        cp1_d      = cp1_q;
        cp2_d      = cp2_q;
        if ((state_q == IDLE || state_q == NEXT) && scrub_en) begin
            ctr_d = scrub_period;
        end else if (state_q == WAIT && ctr_q != '0) begin
            ctr_d = ctr_q - CNT_W'(1);
        end
        if (state_q == NEXT) begin
            addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
        end
        // Counter and address update on entry to FIX so they are visible alongside err_pulse.
        if (state_q == CHECK && state_d == FIX) begin
            err_addr_d = addr_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        if (state_q == FIX) begin
            cp0_d[addr_q] = sc_vote;
            cp1_d[addr_q] = sc_vote;
            cp2_d[addr_q] = sc_vote;
        end
`ifdef TMR_FAULT_INJECT_EN
        if (inj_en) begin
            case (inj_copy)
                2'd0:    cp0_d[inj_addr][inj_bit] = ~cp0_d[inj_addr][inj_bit];
                2'd1:    cp1_d[inj_addr][inj_bit] = ~cp1_d[inj_addr][inj_bit];
                2'd2:    cp2_d[inj_addr][inj_bit] = ~cp2_d[inj_addr][inj_bit];
                default: ;
            endcase
        end
`endif
        // Host write is applied last so it overrides both a repair and an injection.
        if (wr_en) begin
            cp0_d[wr_addr] = wr_data;
            cp1_d[wr_addr] = wr_data;
            cp2_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cp0_q      <= {DEPTH{RESET_VAL}};
            cp1_q      <= {DEPTH{RESET_VAL}};
            cp2_q      <= {DEPTH{RESET_VAL}};
            addr_q     <= '0;
            ctr_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            cp0_q      <= cp0_d;
            cp1_q      <= cp1_d;
            cp2_q      <= cp2_d;
            addr_q     <= addr_d;
            ctr_q      <= ctr_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Randomised bench for tmr_scrub_ctrl, checked every cycle against a word-level scrub reference model.
`timescale 1ns/1ps
module tb_tmr_scrub_ctrl;

    localparam int unsigned      DEPTH     = 8;
    localparam int unsigned      WIDTH     = 8;
    localparam int unsigned      CNT_W     = 8;
    localparam int unsigned      AW        = $clog2(DEPTH);
    localparam int unsigned      BW        = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;
    localparam int unsigned      CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rstn, wr_en, scrub_en, busy, err_pulse;
    logic [AW-1:0]    wr_addr, rd_addr, err_addr;
    logic [WIDTH-1:0] wr_data, rd_data;
    logic [CNT_W-1:0] scrub_period, err_cnt;
`ifdef TMR_FAULT_INJECT_EN
    logic             inj_en;
    logic [AW-1:0]    inj_addr;
    logic [1:0]       inj_copy;
    logic [BW-1:0]    inj_bit;
`else
    logic [DEPTH-1:0][WIDTH-1:0] force_val;
`endif

    always #5 clk = ~clk;

    tmr_scrub_ctrl #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .scrub_en     (scrub_en),
        .scrub_period (scrub_period),
        .busy         (busy),
        .err_pulse    (err_pulse),
        .err_addr     (err_addr),
`ifdef TMR_FAULT_INJECT_EN
        .inj_en       (inj_en),
        .inj_addr     (inj_addr),
        .inj_copy     (inj_copy),
        .inj_bit      (inj_bit),
`endif
        .err_cnt      (err_cnt)
    );

    // Reference model: three copy arrays plus a per-word timeline.
    // Timeline position tl: 0..per waiting, per+1 checking, per+2 repairing (if needed), then advancing.
    logic [WIDTH-1:0] m [3][DEPTH];
    bit               m_active, m_fixing;
    int unsigned      m_tl, m_per, m_addr, m_cnt, m_eaddr;
    bit               i_en;
    int unsigned      i_addr, i_copy, i_bit;
    int unsigned      n_cmp, n_bad;

    function automatic logic [WIDTH-1:0] m_vote(input int unsigned a);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int unsigned b = 0; b < WIDTH; b++)
            v[b] = (int'(m[0][a][b]) + int'(m[1][a][b]) + int'(m[2][a][b])) >= 2;
        return v;
    endfunction

    function automatic bit m_in_fix();
        return m_active && m_fixing && (m_tl == m_per + 2);
    endfunction

    function automatic bit m_in_check();
        return m_active && (m_tl == m_per + 1);
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step();
        bit               do_fix;
        logic [WIDTH-1:0] fixv;
        if (!rstn) begin
            for (int unsigned a = 0; a < DEPTH; a++)
                for (int unsigned c = 0; c < 3; c++) m[c][a] = RESET_VAL;
            m_active = 0; m_fixing = 0; m_tl = 0; m_per = 0;
            m_addr = 0; m_cnt = 0; m_eaddr = 0;
            return;
        end
        do_fix = 0;
        fixv   = '0;
        if (!m_active) begin
            if (scrub_en) begin
                m_active = 1; m_tl = 0; m_per = 32'(scrub_period); m_fixing = 0;
            end
        end else if (m_tl <= m_per) begin
            m_tl++;
        end else if (m_tl == m_per + 1) begin
            m_fixing = !(wr_en && 32'(wr_addr) == m_addr) &&
                       (m[0][m_addr] != m[1][m_addr] || m[1][m_addr] != m[2][m_addr]);
            if (m_fixing) begin
                m_eaddr = m_addr;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            m_tl++;
        end else if (m_fixing && m_tl == m_per + 2) begin
            do_fix = 1;
            fixv   = m_vote(m_addr);
            m_tl++;
        end else begin
            m_addr   = (m_addr + 1) % DEPTH;
            m_fixing = 0;
            if (scrub_en) begin
                m_tl = 0; m_per = 32'(scrub_period);
            end else begin
                m_active = 0;
            end
        end
        if (do_fix)
            for (int unsigned c = 0; c < 3; c++) m[c][m_addr] = fixv;
        if (i_en && i_copy < 3)
            m[i_copy][i_addr][i_bit] = ~m[i_copy][i_addr][i_bit];
        if (wr_en)
            for (int unsigned c = 0; c < 3; c++) m[c][wr_addr] = wr_data;
    endtask

    task automatic tick();
`ifdef TMR_FAULT_INJECT_EN
        inj_en   = i_en;
        inj_addr = AW'(i_addr);
        inj_copy = 2'(i_copy);
        inj_bit  = BW'(i_bit);
`else
        if (i_en && i_copy < 3) begin
            case (i_copy)
                0:       force_val = dut.cp0_q;
                1:       force_val = dut.cp1_q;
                default: force_val = dut.cp2_q;
            endcase
            force_val[i_addr][i_bit] = ~force_val[i_addr][i_bit];
            case (i_copy)
                0:       force dut.cp0_q = force_val;
                1:       force dut.cp1_q = force_val;
                default: force dut.cp2_q = force_val;
            endcase
        end
`endif
        @(posedge clk);
        model_step();
        #1;
`ifndef TMR_FAULT_INJECT_EN
        if (i_en && i_copy < 3) begin
            case (i_copy)
                0:       release dut.cp0_q;
                1:       release dut.cp1_q;
                default: release dut.cp2_q;
            endcase
        end
`endif
        #1;
        chk_eq("busy",      32'(busy),      32'(m_active));
        chk_eq("err_pulse", 32'(err_pulse), 32'(m_in_fix()));
        chk_eq("err_addr",  32'(err_addr),  m_eaddr);
        chk_eq("err_cnt",   32'(err_cnt),   m_cnt);
        chk_eq("rd_data",   32'(rd_data),   32'(m_vote(32'(rd_addr))));
        wr_en = 1'b0;
        i_en  = 0;
`ifdef TMR_FAULT_INJECT_EN
        inj_en = 1'b0;
`endif
    endtask

    task automatic cmp_copies();
        for (int unsigned a = 0; a < DEPTH; a++) begin
            chk_eq($sformatf("copy0[%0d]", a), 32'(dut.cp0_q[a]), 32'(m[0][a]));
            chk_eq($sformatf("copy1[%0d]", a), 32'(dut.cp1_q[a]), 32'(m[1][a]));
            chk_eq($sformatf("copy2[%0d]", a), 32'(dut.cp2_q[a]), 32'(m[2][a]));
        end
    endtask

    // Injections land only while the scrubber is idle or waiting, never alongside a host write.
    task automatic inject(input int unsigned a, input int unsigned c, input int unsigned b);
        for (int unsigned k = 0; k < 200 && m_active && m_tl > m_per; k++) tick();
        i_en = 1; i_addr = a; i_copy = c; i_bit = b;
        wr_en = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int unsigned k = 0; k < 200 && m_active; k++) tick();
        chk_eq("idle_reached", 32'(busy), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit reached;
        n_cmp = 0; n_bad = 0;
        rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        scrub_en = 1'b0; scrub_period = '0; i_en = 0; i_addr = 0; i_copy = 0; i_bit = 0;
`ifdef TMR_FAULT_INJECT_EN
        inj_en = 1'b0; inj_addr = '0; inj_copy = '0; inj_bit = '0;
`endif
        tick(); tick();
        rstn = 1'b1;
        cmp_copies();

        // Plain write and voted read-back.
        rd_addr = AW'(3);
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'hA5;
        tick();
        chk_eq("wr_a5", 32'(rd_data), 32'(8'hA5));
        tick();

        // Single-bit upset repaired by the scrubber with period 0.
        inject(3, 1, 2);
        scrub_en = 1'b1; scrub_period = '0;
        for (int k = 0; k < 30; k++) tick();
        scrub_en = 1'b0;
        wait_idle();
        chk_eq("fix_cnt", 32'(err_cnt), 32'(1));
        cmp_copies();

        // Host write to the word under check cancels its repair.
        inject(2, 0, 5);
        rd_addr = AW'(2);
        scrub_en = 1'b1; scrub_period = CNT_W'(1);
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            if (m_in_check() && m_addr == 2) begin
                wr_en = 1'b1; wr_addr = AW'(2); wr_data = 8'h3C; reached = 1;
            end
            tick();
        end
        chk_eq("cancel_reached", 32'(reached), 32'(1));
        for (int k = 0; k < 4; k++) tick();

        // Host write during repair wins, but the repair is still counted.
        inject(6, 2, 0);
        rd_addr = AW'(6);
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            if (m_in_fix() && m_addr == 6) begin
                wr_en = 1'b1; wr_addr = AW'(6); wr_data = 8'h5A; reached = 1;
            end
            tick();
        end
        chk_eq("fixwr_reached", 32'(reached), 32'(1));
        tick();
        cmp_copies();

        // Clean walk with period 4, then a fault in every word.
        scrub_period = CNT_W'(4);
        for (int k = 0; k < 8 * 7 + 5; k++) tick();
        for (int unsigned a = 0; a < DEPTH; a++) inject(a, $urandom_range(0, 2), $urandom_range(0, WIDTH - 1));
        for (int k = 0; k < 90; k++) tick();
        scrub_en = 1'b0;
        wait_idle();
        cmp_copies();

        // Enough repairs to drive the counter into saturation.
        for (int r = 0; r < 50; r++) begin
            for (int unsigned a = 0; a < DEPTH; a++) inject(a, $urandom_range(0, 2), $urandom_range(0, WIDTH - 1));
            scrub_en = 1'b1; scrub_period = CNT_W'($urandom_range(0, 2));
            for (int k = 0; k < 60; k++) tick();
            scrub_en = 1'b0;
            wait_idle();
        end
        chk_eq("sat_cnt", 32'(err_cnt), CNT_MAX);
        cmp_copies();

        // Random mix of writes, reads, injections, enable toggles and period changes.
        for (int k = 0; k < 800; k++) begin
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            scrub_period = CNT_W'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) scrub_en = ~scrub_en;
            if ($urandom_range(0, 9) == 0 && (!m_active || m_tl <= m_per)) begin
                i_en = 1; i_addr = $urandom_range(0, DEPTH - 1);
                i_copy = $urandom_range(0, 3); i_bit = $urandom_range(0, WIDTH - 1);
            end else if ($urandom_range(0, 3) == 0) begin
                wr_en = 1'b1; wr_addr = AW'($urandom_range(0, DEPTH - 1));
                wr_data = WIDTH'($urandom);
            end
            tick();
        end
        scrub_en = 1'b0;
        wait_idle();
        cmp_copies();

        // Reset asserted while a repair is in flight.
        inject(4, 1, 7);
        scrub_en = 1'b1; scrub_period = '0;
        reached = 0;
        for (int k = 0; k < 200 && !reached; k++) begin
            tick();
            reached = m_in_fix();
        end
        chk_eq("rstfix_reached", 32'(reached), 32'(1));
        scrub_en = 1'b0;
        rstn = 1'b0;
        tick();
        chk_eq("rst_busy", 32'(busy), 32'(0));
        chk_eq("rst_cnt", 32'(err_cnt), 32'(0));
        for (int unsigned a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #0.5;
            chk_eq($sformatf("rst_word[%0d]", a), 32'(rd_data), 32'(RESET_VAL));
        end
        cmp_copies();
        rstn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
